// File: rtl/text_grid_pkg.sv
// Shared command codes, controller state encoding and cell packing for the text grid buffer.
package text_grid_pkg;

    localparam logic [7:0] CMD_LEFT  = 8'h11;
    localparam logic [7:0] CMD_UP    = 8'h12;
    localparam logic [7:0] CMD_DOWN  = 8'h13;
    localparam logic [7:0] CMD_RIGHT = 8'h14;
    localparam logic [7:0] CMD_ENTER = 8'h0D;
    localparam logic [7:0] CMD_BS    = 8'h7F;
    localparam logic [7:0] CMD_FF    = 8'h0C;
    localparam logic [7:0] BLANK     = 8'h00;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CLEAR  = 2'd1;
    localparam logic [1:0] ST_SCROLL = 2'd2;

    // Cell layout is {bg, fg, char}; caller truncates to its cell width.
    function automatic logic [31:0] pack_cell(input logic [31:0] bg, input logic [31:0] fg,
                                              input logic [31:0] ch, input int aw, input int cw);
        return (bg << (aw + cw)) | (fg << aw) | ch;
    endfunction

endpackage

// File: rtl/text_grid_buffer_ram.sv
// One-write, two-read synchronous cell store; both read ports have 1-cycle latency.
// Port B returns only the character field, which is all the host side needs.
module char_grid_ram #(
    parameter int DEPTH = 50,
    parameter int WIDTH = 16,
    parameter int B_W   = 8,
    parameter int AW    = 6
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr_a,
    output logic [WIDTH-1:0] o_rdata_a,
    input  logic [AW-1:0]    i_raddr_b,
    output logic [B_W-1:0]   o_rdata_b
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata_a <= r_mem[i_raddr_a];
        o_rdata_b <= r_mem[i_raddr_b][B_W-1:0];
    end

endmodule

// File: rtl/text_grid_buffer.sv
// Text-mode cell buffer with command decoder, circular-row scroll and blinking cursor.
// Display/host reads are 1-cycle; commands are refused (ready low) during CLEAR/SCROLL sweeps.
module text_grid_buffer
    import text_grid_pkg::*;
#(
    parameter int                     GRID_COL     = 10,
    parameter int                     GRID_ROW     = 5,
    parameter int                     ASCII_WIDTH  = 8,
    parameter int                     COLOR_WIDTH  = 4,
    parameter logic [COLOR_WIDTH-1:0] DEF_FG       = 'hC,
    parameter logic [COLOR_WIDTH-1:0] DEF_BG       = 'h0,
    parameter bit                     SCROLL_EN    = 1'b1,
    parameter int                     BLINK_FRAMES = 30
) (
    input  logic                                    i_clk_pix,
    input  logic                                    i_rst,
    input  logic                                    i_cmd_valid,
    output logic                                    o_cmd_ready,
    input  logic [ASCII_WIDTH-1:0]                  i_cmd_char,
    input  logic [COLOR_WIDTH-1:0]                  i_color_fg,
    input  logic [COLOR_WIDTH-1:0]                  i_color_bg,
    input  logic                                    i_frame_start,
    input  logic [$clog2(GRID_COL)-1:0]             i_disp_col,
    input  logic [$clog2(GRID_ROW)-1:0]             i_disp_row,
    output logic [ASCII_WIDTH+2*COLOR_WIDTH-1:0]    o_disp_bundle,
    output logic                                    o_disp_cursor,
    input  logic [$clog2(GRID_COL*GRID_ROW)-1:0]    i_host_addr,
    output logic [ASCII_WIDTH-1:0]                  o_host_char,
    output logic [$clog2(GRID_COL)-1:0]             o_cursor_col,
    output logic [$clog2(GRID_ROW)-1:0]             o_cursor_row,
    output logic                                    o_busy
);

    localparam int CW     = $clog2(GRID_COL);
    localparam int RW     = $clog2(GRID_ROW);
    localparam int N      = GRID_COL * GRID_ROW;
    localparam int AW     = $clog2(N);
    localparam int CELL_W = ASCII_WIDTH + 2 * COLOR_WIDTH;
    localparam int BW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST_COL = CW'(GRID_COL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(GRID_ROW - 1);

    logic [1:0]             r_state;
    logic [AW-1:0]          r_clr_idx;
    logic [CW-1:0]          r_scr_col, r_cur_col;
    logic [RW-1:0]          r_cur_row, r_top_row;
    logic                   r_blink_on;
    logic [BW-1:0]          r_blink_cnt;
    logic [COLOR_WIDTH-1:0] r_fill_fg, r_fill_bg;
    logic                   r_disp_vld, r_disp_cur, r_host_vld;

    logic                   w_accept, w_moved, w_overflow, w_we, w_disp_in, w_host_in;
    logic [1:0]             w_nxt_state;
    logic [CW-1:0]          w_nxt_col, w_h_col;
    logic [RW-1:0]          w_nxt_row, w_nxt_top, w_h_row;
    logic [AW-1:0]          w_waddr, w_disp_addr, w_host_ram;
    logic [CELL_W-1:0]      w_wdata, w_rd_a;
    logic [ASCII_WIDTH-1:0] w_rd_b;

    function automatic logic [RW-1:0] phys_row(input logic [RW-1:0] lr, input logic [RW-1:0] top);
        logic [RW:0] s;
        s = {1'b0, lr} + {1'b0, top};
        if (s >= (RW+1)'(GRID_ROW)) s = s - (RW+1)'(GRID_ROW);
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] pr, input logic [CW-1:0] col);
        return AW'(pr) * AW'(GRID_COL) + AW'(col);
    endfunction

    assign o_cmd_ready = (r_state == ST_IDLE) && !i_rst;
    assign o_busy      = (r_state != ST_IDLE) || i_rst;
    assign w_accept    = i_cmd_valid && o_cmd_ready;

    always_comb begin
        w_nxt_col   = r_cur_col;
        w_nxt_row   = r_cur_row;
        w_nxt_top   = r_top_row;
        w_nxt_state = r_state;
        w_moved     = 1'b0;
        w_overflow  = 1'b0;
        w_we        = 1'b0;
        w_waddr     = cell_addr(phys_row(r_cur_row, r_top_row), r_cur_col);
        w_wdata     = CELL_W'(pack_cell(32'(i_color_bg), 32'(i_color_fg), 32'(i_cmd_char),
                                        ASCII_WIDTH, COLOR_WIDTH));
        case (r_state)
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_clr_idx;
                w_wdata = CELL_W'(pack_cell(32'(DEF_BG), 32'(DEF_FG), 32'(BLANK), ASCII_WIDTH, COLOR_WIDTH));
                if (r_clr_idx == AW'(N - 1)) w_nxt_state = ST_IDLE;
            end
            ST_SCROLL: begin
                // The new bottom logical row sits on the physical row that just left the top.
                w_we    = 1'b1;
                w_waddr = cell_addr(phys_row(LAST_ROW, r_top_row), r_scr_col);
                w_wdata = CELL_W'(pack_cell(32'(r_fill_bg), 32'(r_fill_fg), 32'(BLANK), ASCII_WIDTH, COLOR_WIDTH));
                if (r_scr_col == LAST_COL) w_nxt_state = ST_IDLE;
            end
            default: if (w_accept) begin
                w_moved = 1'b1;
                case (i_cmd_char)
                    CMD_LEFT: if (r_cur_col != '0) w_nxt_col = r_cur_col - CW'(1);
                              else begin
                                  w_nxt_col = LAST_COL;
                                  w_nxt_row = (r_cur_row == '0) ? LAST_ROW : r_cur_row - RW'(1);
                              end
                    CMD_RIGHT: if (r_cur_col != LAST_COL) w_nxt_col = r_cur_col + CW'(1);
                               else begin
                                   w_nxt_col = '0;
                                   w_nxt_row = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + RW'(1);
                               end
                    CMD_UP:   w_nxt_row = (r_cur_row == '0) ? LAST_ROW : r_cur_row - RW'(1);
                    CMD_DOWN: w_nxt_row = (r_cur_row == LAST_ROW) ? '0 : r_cur_row + RW'(1);
                    CMD_ENTER: begin
                        w_nxt_col = '0;
                        if (r_cur_row == LAST_ROW) w_overflow = 1'b1;
                        else                       w_nxt_row  = r_cur_row + RW'(1);
                    end
                    CMD_BS: if (r_cur_col == '0 && r_cur_row == '0) w_moved = 1'b0;
                            else begin
                                if (r_cur_col != '0) w_nxt_col = r_cur_col - CW'(1);
                                else begin
                                    w_nxt_col = LAST_COL;
                                    w_nxt_row = r_cur_row - RW'(1);
                                end
                                w_we    = 1'b1;
                                w_waddr = cell_addr(phys_row(w_nxt_row, r_top_row), w_nxt_col);
                                w_wdata = CELL_W'(pack_cell(32'(i_color_bg), 32'(i_color_fg), 32'(BLANK),
                                                            ASCII_WIDTH, COLOR_WIDTH));
                            end
                    CMD_FF: begin
                        w_nxt_col   = '0;
                        w_nxt_row   = '0;
                        w_nxt_top   = '0;
                        w_nxt_state = ST_CLEAR;
                    end
                    default: begin
                        w_we = 1'b1;
                        if (r_cur_col != LAST_COL) w_nxt_col = r_cur_col + CW'(1);
                        else begin
                            w_nxt_col = '0;
                            if (r_cur_row == LAST_ROW) w_overflow = 1'b1;
                            else                       w_nxt_row  = r_cur_row + RW'(1);
                        end
                    end
                endcase
                if (w_overflow) begin
                    w_nxt_col = '0;
                    if (SCROLL_EN) begin
                        w_nxt_top   = (r_top_row == LAST_ROW) ? '0 : r_top_row + RW'(1);
                        w_nxt_row   = LAST_ROW;
                        w_nxt_state = ST_SCROLL;
                    end else begin
                        w_nxt_row = '0;
                    end
                end
            end
        endcase
    end

    assign w_disp_in   = ({1'b0, i_disp_col} < (CW+1)'(GRID_COL)) && ({1'b0, i_disp_row} < (RW+1)'(GRID_ROW));
    assign w_disp_addr = w_disp_in ? cell_addr(phys_row(i_disp_row, r_top_row), i_disp_col) : '0;
    assign w_host_in   = {1'b0, i_host_addr} < (AW+1)'(N);
    assign w_h_row     = RW'(i_host_addr / AW'(GRID_COL));
    assign w_h_col     = CW'(i_host_addr % AW'(GRID_COL));
    assign w_host_ram  = w_host_in ? cell_addr(phys_row(w_h_row, r_top_row), w_h_col) : '0;

    always_ff @(posedge i_clk_pix) begin
        if (i_rst) begin
            r_state     <= ST_CLEAR;
            r_clr_idx   <= '0;
            r_scr_col   <= '0;
            r_cur_col   <= '0;
            r_cur_row   <= '0;
            r_top_row   <= '0;
            r_blink_on  <= 1'b1;
            r_blink_cnt <= '0;
            r_fill_fg   <= '0;
            r_fill_bg   <= '0;
            r_disp_vld  <= 1'b0;
            r_disp_cur  <= 1'b0;
            r_host_vld  <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cur_col <= w_nxt_col;
            r_cur_row <= w_nxt_row;
            r_top_row <= w_nxt_top;
            r_clr_idx <= (r_state == ST_CLEAR)  ? r_clr_idx + AW'(1) : '0;
            r_scr_col <= (r_state == ST_SCROLL) ? r_scr_col + CW'(1) : '0;
            if (w_accept) begin
                r_fill_fg <= i_color_fg;
                r_fill_bg <= i_color_bg;
            end
            if (w_moved) begin
                r_blink_on  <= 1'b1;
                r_blink_cnt <= '0;
            end else if (i_frame_start && BLINK_FRAMES != 0) begin
                if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= !r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + BW'(1);
                end
            end
            r_disp_vld <= w_disp_in;
            r_disp_cur <= w_disp_in && (i_disp_row == r_cur_row) && (i_disp_col == r_cur_col) && r_blink_on;
            r_host_vld <= w_host_in;
        end
    end

    char_grid_ram #(.DEPTH(N), .WIDTH(CELL_W), .B_W(ASCII_WIDTH), .AW(AW)) u_ram (
        .i_clk     (i_clk_pix),
        .i_we      (w_we),
        .i_waddr   (w_waddr),
        .i_wdata   (w_wdata),
        .i_raddr_a (w_disp_addr),
        .o_rdata_a (w_rd_a),
        .i_raddr_b (w_host_ram),
        .o_rdata_b (w_rd_b)
    );

    assign o_disp_bundle = r_disp_vld ? w_rd_a : '0;
    assign o_disp_cursor = r_disp_cur;
    assign o_host_char   = r_host_vld ? w_rd_b : '0;
    assign o_cursor_col  = r_cur_col;
    assign o_cursor_row  = r_cur_row;

endmodule

// File: tb/tb_text_grid_buffer.sv
// Directed + randomized bench: logical-grid model (rows shift on scroll) checked against the buffer.
module tb_text_grid_buffer;

    localparam int C  = 10;
    localparam int R  = 5;
    localparam int N  = C * R;
    localparam int BF = 2;

    logic        clk = 1'b0;
    logic        rst, cmd_valid, cmd_ready, frame_start, disp_cursor, busy;
    logic [7:0]  cmd_char, host_char;
    logic [3:0]  color_fg, color_bg, disp_col, cursor_col;
    logic [2:0]  disp_row, cursor_row;
    logic [15:0] disp_bundle;
    logic [5:0]  host_addr;

    always #5 clk = ~clk;

    text_grid_buffer #(.BLINK_FRAMES(BF)) dut (
        .i_clk_pix(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_char(cmd_char), .i_color_fg(color_fg), .i_color_bg(color_bg),
        .i_frame_start(frame_start), .i_disp_col(disp_col), .i_disp_row(disp_row),
        .o_disp_bundle(disp_bundle), .o_disp_cursor(disp_cursor), .i_host_addr(host_addr),
        .o_host_char(host_char), .o_cursor_col(cursor_col), .o_cursor_row(cursor_row), .o_busy(busy)
    );

    // Reference: logical screen as seen by the user; scrolling physically moves rows.
    logic [7:0] m_ch [R][C];
    logic [3:0] m_fg [R][C];
    logic [3:0] m_bg [R][C];
    int         mr, mc, m_cnt;
    bit         m_blink;
    int         n_vec = 0, n_bad = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                m_ch[r][c] = 8'h00; m_fg[r][c] = 4'hC; m_bg[r][c] = 4'h0;
            end
        mr = 0; mc = 0; m_blink = 1; m_cnt = 0;
    endtask

    task automatic model_cmd(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg, output int busy_len);
        int idx;
        bit ovf, touch;
        idx = mr * C + mc; ovf = 0; touch = 1; busy_len = 0;
        case (c)
            8'h11: idx = (idx + N - 1) % N;
            8'h14: idx = (idx + 1) % N;
            8'h12: idx = ((mr + R - 1) % R) * C + mc;
            8'h13: idx = ((mr + 1) % R) * C + mc;
            8'h0D: if (mr == R - 1) ovf = 1; else idx = (mr + 1) * C;
            8'h7F: if (idx == 0) touch = 0;
                   else begin
                       idx--;
                       m_ch[idx / C][idx % C] = 8'h00; m_fg[idx / C][idx % C] = fg; m_bg[idx / C][idx % C] = bg;
                   end
            8'h0C: begin model_clear(); idx = 0; busy_len = N; end
            default: begin
                m_ch[mr][mc] = c; m_fg[mr][mc] = fg; m_bg[mr][mc] = bg;
                if (idx == N - 1) ovf = 1; else idx++;
            end
        endcase
        if (ovf) begin
            for (int r = 0; r < R - 1; r++)
                for (int k = 0; k < C; k++) begin
                    m_ch[r][k] = m_ch[r + 1][k]; m_fg[r][k] = m_fg[r + 1][k]; m_bg[r][k] = m_bg[r + 1][k];
                end
            for (int k = 0; k < C; k++) begin
                m_ch[R - 1][k] = 8'h00; m_fg[R - 1][k] = fg; m_bg[R - 1][k] = bg;
            end
            idx = (R - 1) * C;
            busy_len = C;
        end
        mr = idx / C; mc = idx % C;
        if (touch) begin m_blink = 1; m_cnt = 0; end
    endtask

    task automatic send(input logic [7:0] c, input logic [3:0] fg, input logic [3:0] bg, input bit drain);
        int n, exp_busy;
        n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        if (!cmd_ready) chk("ready_wait", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1; cmd_char = c; color_fg = fg; color_bg = bg;
        tick();
        cmd_valid = 0;
        model_cmd(c, fg, bg, exp_busy);
        chk("cursor_row", cursor_row, mr);
        chk("cursor_col", cursor_col, mc);
        chk("busy_after_accept", {31'd0, busy}, {31'd0, exp_busy != 0});
        if (drain && exp_busy != 0) begin
            n = 0;
            while (busy && n < 200) begin tick(); n++; end
            chk("busy_len", n, exp_busy);
        end
    endtask

    task automatic scan;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) begin
                disp_row = 3'(r); disp_col = 4'(c); host_addr = 6'(r * C + c);
                tick();
                chk("disp_bundle", disp_bundle, {m_bg[r][c], m_fg[r][c], m_ch[r][c]});
                chk("disp_cursor", {31'd0, disp_cursor}, {31'd0, (r == mr && c == mc && m_blink)});
                chk("host_char", host_char, m_ch[r][c]);
            end
        host_addr = 6'd55;
        tick();
        chk("host_oob", host_char, 8'h00);
    endtask

    task automatic pulse_and_check;
        frame_start = 1;
        tick();
        frame_start = 0;
        m_cnt++;
        if (m_cnt == BF) begin m_cnt = 0; m_blink = !m_blink; end
        disp_row = 3'(mr); disp_col = 4'(mc);
        tick();
        chk("blink_phase", {31'd0, disp_cursor}, {31'd0, m_blink});
    endtask

    task automatic wait_clear;
        int n;
        n = 0;
        do begin tick(); n++; end while (!cmd_ready && n < 200);
        cmd_valid = 0;
        chk("clear_len", n, N);
    endtask

    initial begin
        logic [7:0] rc;
        rst = 1; cmd_valid = 1; cmd_char = 8'h41; color_fg = 0; color_bg = 0;
        frame_start = 0; disp_col = 0; disp_row = 0; host_addr = 0;
        repeat (3) tick();
        chk("rst_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_disp", disp_bundle, 16'h0);
        chk("rst_disp_cursor", {31'd0, disp_cursor}, 32'd0);
        chk("rst_host", host_char, 8'h00);
        chk("rst_cur_row", cursor_row, 0);
        chk("rst_cur_col", cursor_col, 0);
        rst = 0;
        wait_clear();
        model_clear();
        chk("post_clr_row", cursor_row, mr);
        chk("post_clr_col", cursor_col, mc);
        scan();

        send(8'h41, 4'd3, 4'd1, 1);
        disp_row = 0; disp_col = 0; host_addr = 0;
        tick();
        chk("A_disp", disp_bundle, 16'h1341);
        chk("A_host", host_char, 8'h41);

        send(8'h11, 4'd0, 4'd0, 1);
        for (int i = 0; i < N; i++)
            send(8'(8'h30 + i % 10), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
        scan();

        send(8'h13, 4'd2, 4'd5, 1);
        send(8'h11, 4'd2, 4'd5, 1);
        send(8'h14, 4'd2, 4'd5, 1);
        send(8'h7F, 4'd2, 4'd5, 1);
        scan();

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: rc = 8'h11;
                1: rc = 8'h14;
                2: rc = 8'h12;
                3: rc = 8'h13;
                4: rc = 8'h0D;
                5: rc = 8'h7F;
                default: rc = 8'($urandom_range(8'h20, 8'h7E));
            endcase
            send(rc, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1);
        end
        scan();

        send(8'h14, 4'd1, 4'd1, 1);
        repeat (6) pulse_and_check();
        send(8'h14, 4'd1, 4'd1, 1);
        disp_row = 3'(mr); disp_col = 4'(mc);
        tick();
        chk("blink_forced_on", {31'd0, disp_cursor}, {31'd0, m_blink});

        disp_row = 0; disp_col = 4'd12;
        tick();
        chk("oob_col_bundle", disp_bundle, 16'h0);
        chk("oob_col_cursor", {31'd0, disp_cursor}, 32'd0);
        disp_row = 3'd6; disp_col = 0;
        tick();
        chk("oob_row_bundle", disp_bundle, 16'h0);

        send(8'h51, 4'd7, 4'd2, 1);
        send(8'h52, 4'd7, 4'd2, 1);
        send(8'h0C, 4'd7, 4'd2, 0);
        repeat (7) tick();
        rst = 1;
        tick();
        chk("rst_in_clear_ready", {31'd0, cmd_ready}, 32'd0);
        chk("rst_in_clear_busy", {31'd0, busy}, 32'd1);
        tick();
        rst = 0;
        wait_clear();
        model_clear();
        chk("ff_cur_row", cursor_row, mr);
        chk("ff_cur_col", cursor_col, mc);
        scan();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/text_grid_buffer.md
Name: text_grid_buffer

Overview:
Single-clock successor to the text-mode display buffer for the VGA typewriter. It holds a GRID_ROW x GRID_COL array of {bg,fg,char} cells and a command decoder for characters, cursor moves, enter, backspace and clear. It adds hardware scroll through a circular row base, a blinking cursor flag that never overwrites cell data, and a valid/ready command handshake. It sits between the keyboard/host command source and the pixel pipeline (magnifier, glyph ROM, CLUT).

Parameters:
GRID_COL, 10, characters per row
GRID_ROW, 5, character rows
ASCII_WIDTH, 8, character code width
COLOR_WIDTH, 4, CLUT index width; cell width CELL_W = ASCII_WIDTH + 2*COLOR_WIDTH
DEF_FG, 4'hC, foreground index written by reset-clear
DEF_BG, 4'h0, background index written by reset-clear
SCROLL_EN, 1, 1 = scroll on bottom overflow; 0 = wrap to (0,0)
BLINK_FRAMES, 30, frame_start pulses per blink phase; 0 = cursor steady on

Ports:
clk_pix  in  1  pixel clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted on a cycle where cmd_valid && cmd_ready
cmd_char  in  ASCII_WIDTH  command or character code
color_fg  in  COLOR_WIDTH  foreground index for written cells
color_bg  in  COLOR_WIDTH  background index for written cells
frame_start  in  1  one-cycle pulse per video frame
disp_col  in  clog2(GRID_COL)  logical display column
disp_row  in  clog2(GRID_ROW)  logical display row
disp_bundle  out  CELL_W  {bg,fg,char} for (disp_row,disp_col)
disp_cursor  out  1  cursor highlight for the same cell
host_addr  in  clog2(GRID_COL*GRID_ROW)  logical linear index, row*GRID_COL+col
host_char  out  ASCII_WIDTH  character at host_addr
cursor_col  out  clog2(GRID_COL)  current cursor column
cursor_row  out  clog2(GRID_ROW)  current logical cursor row
busy  out  1  high in CLEAR or SCROLL

Behaviour:
- Reset: the single clock is clk_pix; reset rst is synchronous and active-high. While rst=1: cmd_ready=0, busy=1, disp_bundle=0, disp_cursor=0, host_char=0, cursor=(0,0), top_row=0, blink phase=on, state=CLEAR with clr_idx=0. rst overrides every other input.
- States:
  - IDLE: cmd_ready=1.
  - CLEAR: writes {DEF_BG,DEF_FG,0} to one cell per cycle for N=GRID_COL*GRID_ROW cycles, then goes to IDLE.
  - SCROLL: writes {color_bg,color_fg,0}, captured at accept, across the new bottom physical row, GRID_COL cycles, then goes to IDLE.
  - cmd_ready=0 and busy=1 in CLEAR and SCROLL. Commands during busy are not accepted.
- Address mapping: phys_row = (logical_row + top_row) mod GRID_ROW; addr = phys_row*GRID_COL + col.
- Commands take effect on the accept edge; the cursor outputs update the next cycle.
  - 0x11 left / 0x14 right: move linearly through the cells; wrap (0,0) <-> (GRID_ROW-1,GRID_COL-1); never scroll.
  - 0x12 up / 0x13 down: row -/+1 with wrap; never scroll.
  - 0x0D enter: col=0, row+1.
  - 0x7F backspace: at (0,0) no-op; otherwise move back one cell and write a blank cell.
  - 0x0C form feed: cursor=(0,0), top_row=0, enter CLEAR using DEF colors.
  - Any other code: write {color_bg,color_fg,cmd_char} at the cursor, then advance; last column wraps to col 0 of the next row.
- Overflow (advance or enter past the last row):
  - SCROLL_EN=1: top_row increments mod GRID_ROW, cursor=(GRID_ROW-1,0), enter SCROLL.
  - SCROLL_EN=0: cursor=(0,0), no state change.
- Display read: registered, 1-cycle latency. Coordinates out of range give disp_bundle=0 and disp_cursor=0.
- disp_cursor = 1 when the coordinates equal the cursor and the blink phase is on; it is aligned with disp_bundle.
- Blink: a counter of frame_start pulses toggles the phase every BLINK_FRAMES pulses. It runs in every state. Each cursor move or accepted write forces phase on and resets the counter.
- Host read: 1-cycle latency; host_addr >= N returns 0.
- Reads during CLEAR/SCROLL return the in-progress contents; no stall.
- Storage: 1 write port, 2 synchronous read ports, inferable as RAM.

Decomposition:
- Package text_grid_pkg holds:
  - command code constants (CMD_LEFT, CMD_RIGHT, CMD_UP, CMD_DOWN, CMD_ENTER, CMD_BS, CMD_FF);
  - the BLANK code 0x00;
  - the state encoding (IDLE, CLEAR, SCROLL);
  - the pack_cell function.
- Sub-module char_grid_ram: 1-write/2-read synchronous RAM of N x CELL_W.

Test Plan:
- Release rst and hold cmd_valid=1 -> cmd_ready=0 for exactly 50 cycles; then every host_addr reads 0x00; cursor=(0,0).
- Write 'A' (0x41) with fg=3, bg=1 at (0,0) -> host_addr 0 reads 0x41; disp at (0,0) gives 0x1341 one cycle later; cursor=(0,1).
- Write 50 chars 0x30+i%10 with SCROLL_EN=1 -> on the 50th char, busy for 10 cycles; logical row 4 is blank; logical row 0 holds the former row 1; cursor=(4,0).
- Issue left at (0,0), then backspace at (0,0) -> left gives cursor (4,9); backspace at (0,0) changes nothing, no writes.
- BLINK_FRAMES=2: pulse frame_start 4 times with no commands -> disp_cursor at the cursor cell goes on, off, on; a right command forces it on.
- Issue form feed mid-line, assert rst during CLEAR -> cmd_ready=0 the cycle after rst; CLEAR restarts with a full 50-cycle sweep.
